output_layer_seq: RTL and testbench

//  Sequencer and MAC that consumes the output-layer weight RAM (registered read address: data valid the

---
 rtl/output_layer_seq.sv | 181 ++++++++++++++++++
 tb/tb_output_layer_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_layer_seq.sv
// output_layer_seq: weight-RAM sequencer + signed MAC with scale/saturate per neuron; OUTPUT_ARGMAX_EN adds argmax_idx/argmax_valid.
// Latency N_INPUTS+2 cycles per neuron; a pending result holds stable and stalls the pass while res_valid && !res_ready.
module output_layer_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int N_INPUTS   = 32,
    parameter int N_OUTPUTS  = 10,
    parameter int ACC_WIDTH  = 24,
    parameter int FRAC_BITS  = 0,
    localparam int IW = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
    localparam int JW = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_q,
    output logic [IW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_q,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [JW-1:0]         res_idx,
    output logic                  busy,
    output logic                  done
`ifdef OUTPUT_ARGMAX_EN
    ,
    output logic [JW-1:0]         argmax_idx,
    output logic                  argmax_valid
`endif
);

    generate
        if (longint'(N_INPUTS) * longint'(N_OUTPUTS) > (64'sd1 <<< ADDR_WIDTH)) begin : g_addr_chk
            $error("output_layer_seq: N_INPUTS*N_OUTPUTS exceeds the weight RAM address space");
        end
        if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(N_INPUTS)) begin : g_acc_chk
            $error("output_layer_seq: ACC_WIDTH too narrow for a full-length dot product");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_EMIT, S_DONE} state_t;

    localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUTPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                        state_q;
    logic [IW-1:0]                 i_q;
    logic [JW-1:0]                 j_q;
    logic                          rd_vld_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [ACC_WIDTH-1:0]   acc_shift;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]         sat_d;
    logic                          res_valid_q;
    logic [DATA_WIDTH-1:0]         res_data_q;
    logic [JW-1:0]                 res_idx_q;
    logic                          busy_q;
    logic                          done_q;

    // Read data lags its address by one cycle, so rd_vld_q gates accumulation.
    assign prod      = $signed(w_q) * $signed(a_q);
    assign acc_d     = rd_vld_q ? acc_q + ACC_WIDTH'(prod) : acc_q;
    assign acc_shift = acc_d >>> FRAC_BITS;

    always_comb begin
        sat_d = acc_shift[DATA_WIDTH-1:0];
        if (acc_shift > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    assign w_addr    = ADDR_WIDTH'(int'(j_q) * N_INPUTS + int'(i_q));
    assign a_addr    = i_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            rd_vld_q    <= 1'b0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_vld_q <= (state_q == S_ACCUM);
            acc_q    <= acc_d;
            done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ACCUM;
                        busy_q  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (i_q == I_LAST) begin
                        i_q     <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                // The last product lands in acc_d this cycle, so saturate from it directly.
                S_DRAIN: begin
                    state_q     <= S_EMIT;
                    res_valid_q <= 1'b1;
                    res_data_q  <= sat_d;
                    res_idx_q   <= j_q;
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        acc_q       <= '0;
                        if (j_q == J_LAST) begin
                            j_q     <= '0;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            j_q     <= j_q + JW'(1);
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef OUTPUT_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] best_q;
    logic [JW-1:0]                best_idx_q;
    logic                         argmax_valid_q;

    // Strict greater-than keeps the lowest index on ties; neuron 0 always seeds the search.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q         <= '0;
            best_idx_q     <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            argmax_valid_q <= 1'b0;
            if (state_q == S_IDLE && start) begin
                best_q     <= '0;
                best_idx_q <= '0;
            end else if (state_q == S_EMIT && res_ready) begin
                if (j_q == '0 || $signed(res_data_q) > best_q) begin
                    best_q     <= $signed(res_data_q);
                    best_idx_q <= j_q;
                end
                if (j_q == J_LAST) begin
                    argmax_valid_q <= 1'b1;
                end
            end
        end
    end

    assign argmax_idx   = best_idx_q;
    assign argmax_valid = argmax_valid_q;
`endif

endmodule

// File: tb/tb_output_layer_seq.sv
// Bench for output_layer_seq (N_INPUTS=4, N_OUTPUTS=3): RAM model, queue-based result model and directed passes.
// Build with OUTPUT_ARGMAX_EN defined to also exercise the argmax outputs.
module tb_output_layer_seq;
    localparam int DW = 8, AW = 8, NI = 4, NO = 3, ACCW = 24, FB = 0;

    logic          clk = 1'b0;
    logic          rst, start, res_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_q, a_q;
    logic [1:0]    a_addr;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [1:0]    res_idx;
    logic          busy, done;
`ifdef OUTPUT_ARGMAX_EN
    logic [1:0]    argmax_idx;
    logic          argmax_valid;
`endif

    output_layer_seq #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_INPUTS(NI), .N_OUTPUTS(NO),
        .ACC_WIDTH(ACCW), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .w_addr(w_addr), .w_q(w_q), .a_addr(a_addr), .a_q(a_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done)
`ifdef OUTPUT_ARGMAX_EN
        , .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int data; int idx; } exp_t;

    int   w_mem [NI*NO];
    int   a_mem [NI];
    exp_t expq [$];
    int   rises [$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, start_cyc = 0, done_rel = -1;
    bit   prev_vld = 1'b0, exp_done = 1'b0;
    int   am_exp = 0;

    // Registered-read RAMs: data appears the cycle after the address.
    always @(posedge clk) begin
        w_q <= (int'(w_addr) < NI*NO) ? w_mem[w_addr][DW-1:0] : '0;
        a_q <= a_mem[a_addr][DW-1:0];
    end

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int model(int j);
        int s = 0;
        for (int i = 0; i < NI; i++) s += w_mem[j*NI+i] * a_mem[i];
        s = s >>> FB;
        if (s > (1 << (DW-1)) - 1) s = (1 << (DW-1)) - 1;
        else if (s < -(1 << (DW-1))) s = -(1 << (DW-1));
        return s;
    endfunction

    function automatic int model_argmax();
        int best = 0;
        for (int j = 1; j < NO; j++) if (model(j) > model(best)) best = j;
        return best;
    endfunction

    // Every cycle: results must match the queue head in order; done must follow the last accepted result.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_vld = 1'b0;
            exp_done = 1'b0;
        end else begin
            chk("done", int'(done), int'(exp_done));
`ifdef OUTPUT_ARGMAX_EN
            chk("argmax_valid", int'(argmax_valid), int'(exp_done));
            if (exp_done) chk("argmax_idx", int'(argmax_idx), am_exp);
`endif
            if (done) done_rel = cyc - start_cyc;
            exp_done = 1'b0;
            if (res_valid && !prev_vld) rises.push_back(cyc - start_cyc);
            if (res_valid) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL res_valid: got 1 with no result pending, expected 0");
                end else begin
                    chk("res_data", int'($signed(res_data)), expq[0].data);
                    chk("res_idx", int'(res_idx), expq[0].idx);
                    if (res_ready) begin
                        void'(expq.pop_front());
                        exp_done = (expq.size() == 0);
                    end
                end
            end
            prev_vld = res_valid;
        end
    end

    task automatic push_pass();
        for (int j = 0; j < NO; j++) begin
            exp_t e;
            e.data = model(j);
            e.idx  = j;
            expq.push_back(e);
        end
        am_exp = model_argmax();
    endtask

    task automatic start_pass(input bit hold);
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc + 1;
        rises.delete();
        done_rel  = -1;
        if (!hold) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_rel < 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen_before_timeout", int'(done_rel >= 0), 1);
        chk("busy_in_done_cycle", int'(busy), 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("busy_idle_after_done", int'(busy), 0);
        end
        chk("results_outstanding", expq.size(), 0);
    endtask

    task automatic chk_timing(input int r0, input int r1, input int r2, input int d);
        chk("rise_count", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("first_valid_cycle", rises[0], r0);
            chk("second_valid_cycle", rises[1], r1);
            chk("third_valid_cycle", rises[2], r2);
        end
        chk("done_cycle", done_rel, d);
    endtask

    task automatic wait_valid_idx(input int idx);
        int n = 0;
        while (!(res_valid && int'(res_idx) == idx) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("valid_seen_before_timeout", int'(res_valid && int'(res_idx) == idx), 1);
    endtask

    initial begin
        int sd, sidx, swa;
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        foreach (w_mem[k]) w_mem[k] = 0;
        foreach (a_mem[k]) a_mem[k] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_idx", int'(res_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_a_addr", int'(a_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pass A: unit weights, activations 1..4, addresses and latency pinned cycle by cycle.
        foreach (w_mem[k]) w_mem[k] = 1;
        for (int i = 0; i < NI; i++) a_mem[i] = i + 1;
        chk("model_pin_sum10", model(0), 10);
        push_pass();
        start_pass(1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            if (k <= 4) begin
                chk("accum_a_addr", int'(a_addr), k - 1);
                chk("accum_w_addr", int'(w_addr), k - 1);
            end
            if (k == 5) chk("drain_res_valid", int'(res_valid), 0);
            if (k == 6) chk("emit_res_valid", int'(res_valid), 1);
        end
        wait_done();
        chk_timing(6, 12, 18, 19);

        // Pass B: positive and negative saturation.
        foreach (w_mem[k]) w_mem[k] = 127;
        foreach (a_mem[k]) a_mem[k] = 127;
        chk("model_pin_sat_pos", model(0), 127);
        push_pass();
        start_pass(1'b0);
        wait_done();
        foreach (w_mem[k]) w_mem[k] = -128;
        chk("model_pin_sat_neg", model(1), -128);
        push_pass();
        start_pass(1'b0);
        wait_done();

        // Pass C: distinct signed rows, consumer stalls 5 EMIT cycles on neuron 1.
        foreach (w_mem[k]) w_mem[k] = k - 6;
        for (int i = 0; i < NI; i++) a_mem[i] = i + 1;
        chk("model_pin_row0", model(0), -40);
        chk("model_pin_row1", model(1), 0);
        chk("model_pin_row2", model(2), 40);
        push_pass();
        start_pass(1'b0);
        wait_valid_idx(0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        wait_valid_idx(1);
        sd = int'(res_data); sidx = int'(res_idx); swa = int'(w_addr);
        chk("stall_w_addr_pin", swa, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("stall_res_valid", int'(res_valid), 1);
            chk("stall_res_data", int'(res_data), sd);
            chk("stall_res_idx", int'(res_idx), sidx);
            chk("stall_w_addr", int'(w_addr), swa);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done();
        chk_timing(6, 12, 23, 24);

        // Reset in neuron 1 accumulation: partial pass discarded, fresh pass starts at neuron 0.
        push_pass();
        start_pass(1'b0);
        repeat (7) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_res_valid", int'(res_valid), 0);
        chk("post_rst_res_idx", int'(res_idx), 0);
        chk("post_rst_w_addr", int'(w_addr), 0);
        expq.delete();
        push_pass();
        start_pass(1'b0);
        wait_done();
        chk_timing(6, 12, 18, 19);

        // start held high across the whole pass: must not restart or shift timing.
        push_pass();
        start_pass(1'b1);
        wait_done();
        chk_timing(6, 12, 18, 19);

`ifdef OUTPUT_ARGMAX_EN
        // Row sums {5,-3,5}: tie resolves to the lower index.
        foreach (a_mem[k]) a_mem[k] = 1;
        w_mem = '{1, 1, 1, 2, -1, -1, -1, 0, 2, 1, 1, 1};
        chk("model_pin_argmax", model_argmax(), 0);
        push_pass();
        start_pass(1'b0);
        wait_done();
        chk("argmax_idx_held", int'(argmax_idx), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
